// File: rtl/game_pkg.sv
// game_pkg: definitions shared by the race referee and the game_logic-side
// displays.
//   phase_e       : referee FSM state encoding, also driven on the phase port
//   STATUS_OK_BIT : bit of a player's status_code that means "OK to display"
//   PLACE_W       : width of one rank field in place_bus
//   POS_W         : width of one position / status field
//   place_inc     : next rank value, saturating at the largest encodable rank
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        GREEN     = 3'd2,
        RED       = 3'd3,
        DONE      = 3'd4
    } phase_e;

    localparam int STATUS_OK_BIT = 3;
    localparam int PLACE_W       = 3;
    localparam int POS_W         = 4;

    function automatic logic [PLACE_W-1:0] place_inc(input logic [PLACE_W-1:0] p);
        return (p == 3'd7) ? p : p + 3'd1;
    endfunction

endpackage

// File: rtl/race_referee_if.sv
// race_referee_if: per-player game_logic link between the referee and the
// player lanes.
//   enable, red, win        : referee -> players (light state, rank pulse)
//   max_clicks, max_steps   : referee -> players (latched targets)
//   position_bus            : players -> referee, lane i at [4i+3:4i]
//   status_bus              : players -> referee, lane i at [4i+3:4i]
// Modports: master = referee side, slave = player side.
interface race_referee_if #(
    parameter int NUM_PLAYERS = 4
);
    logic                                   enable;
    logic                                   red;
    logic                                   win;
    logic [game_pkg::POS_W-1:0]             max_clicks;
    logic [game_pkg::POS_W-1:0]             max_steps;
    logic [game_pkg::POS_W*NUM_PLAYERS-1:0] position_bus;
    logic [game_pkg::POS_W*NUM_PLAYERS-1:0] status_bus;

    modport master (
        output enable, red, win, max_clicks, max_steps,
        input  position_bus, status_bus
    );

    modport slave (
        input  enable, red, win, max_clicks, max_steps,
        output position_bus, status_bus
    );
endinterface

// File: rtl/race_referee_light_sequencer.sv
// light_sequencer: IDLE -> COUNTDOWN -> GREEN <-> RED -> DONE light FSM.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : level, accepted only in IDLE or DONE
//   force_done   : every lane is resolved; overrides the phase timer
//   load_o       : start accepted this cycle (referee relatches/clears)
//   phase_o      : current state
//   enable_o, red_o, game_over_o : registered light outputs
module light_sequencer
    import game_pkg::*;
#(
    parameter int COUNTDOWN_CYCLES = 3,
    parameter int GREEN_CYCLES     = 8,
    parameter int RED_CYCLES       = 4,
    parameter int TIMER_W          = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   force_done,
    output logic   load_o,
    output phase_e phase_o,
    output logic   enable_o,
    output logic   red_o,
    output logic   game_over_o
);
    localparam logic [TIMER_W-1:0] CD_LOAD = TIMER_W'(COUNTDOWN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GR_LOAD = TIMER_W'(GREEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RD_LOAD = TIMER_W'(RED_CYCLES - 1);

    phase_e             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               enable_q;
    logic               red_q;
    logic               game_over_q;

    assign load_o      = start && ((state_q == IDLE) || (state_q == DONE));
    assign phase_o     = state_q;
    assign enable_o    = enable_q;
    assign red_o       = red_q;
    assign game_over_o = game_over_q;

    // Light FSM; enable/red/game_over are written together with the state so
    // they change in the same cycle as the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            enable_q    <= 1'b0;
            red_q       <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q     <= COUNTDOWN;
                        timer_q     <= CD_LOAD;
                        enable_q    <= 1'b0;
                        red_q       <= 1'b1;
                        game_over_q <= 1'b0;
                    end
                end
                COUNTDOWN: begin
                    if (timer_q == '0) begin
                        state_q  <= GREEN;
                        timer_q  <= GR_LOAD;
                        enable_q <= 1'b1;
                        red_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                GREEN, RED: begin
                    // Game over wins over a phase change in the same cycle.
                    if (force_done) begin
                        state_q     <= DONE;
                        enable_q    <= 1'b0;
                        red_q       <= 1'b1;
                        game_over_q <= 1'b1;
                    end else if (timer_q == '0) begin
                        if (state_q == GREEN) begin
                            state_q <= RED;
                            timer_q <= RD_LOAD;
                            red_q   <= 1'b1;
                        end else begin
                            state_q <= GREEN;
                            timer_q <= GR_LOAD;
                            red_q   <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    timer_q     <= '0;
                    enable_q    <= 1'b0;
                    red_q       <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/race_referee.sv
// race_referee: central referee of the click race.
//   clk, rst               : clock, asynchronous active-high reset
//   start                  : level, sampled in IDLE or DONE
//   cfg_clicks, cfg_steps  : targets, latched when start is accepted
//   bus (master)           : enable/red/win/max_* out, position/status in
//   finished, eliminated   : per-lane result flags
//   place_bus              : rank of lane i at [3i+2:3i], 0 = unranked
//   game_over, phase       : DONE flag and FSM state
module race_referee
    import game_pkg::*;
#(
    parameter int NUM_PLAYERS      = 4,
    parameter int COUNTDOWN_CYCLES = 3,
    parameter int GREEN_CYCLES     = 8,
    parameter int RED_CYCLES       = 4,
    parameter int TIMER_W          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [POS_W-1:0]               cfg_clicks,
    input  logic [POS_W-1:0]               cfg_steps,
    race_referee_if.master                 bus,
    output logic [NUM_PLAYERS-1:0]         finished,
    output logic [NUM_PLAYERS-1:0]         eliminated,
    output logic [PLACE_W*NUM_PLAYERS-1:0] place_bus,
    output logic                           game_over,
    output logic [2:0]                     phase
);
    phase_e                         phase_s;
    logic                           load_s;
    logic                           eval_s;
    logic                           force_done_s;
    logic                           picked_s;

    logic [NUM_PLAYERS-1:0]         finished_q,   finished_d;
    logic [NUM_PLAYERS-1:0]         eliminated_q, eliminated_d;
    logic [PLACE_W*NUM_PLAYERS-1:0] place_q,      place_d;
    logic [PLACE_W-1:0]             next_place_q, next_place_d;
    logic                           win_q,        win_d;
    logic [POS_W-1:0]               max_clicks_q, max_clicks_d;
    logic [POS_W-1:0]               max_steps_q,  max_steps_d;

    light_sequencer #(
        .COUNTDOWN_CYCLES (COUNTDOWN_CYCLES),
        .GREEN_CYCLES     (GREEN_CYCLES),
        .RED_CYCLES       (RED_CYCLES),
        .TIMER_W          (TIMER_W)
    ) u_lights (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .force_done  (force_done_s),
        .load_o      (load_s),
        .phase_o     (phase_s),
        .enable_o    (bus.enable),
        .red_o       (bus.red),
        .game_over_o (game_over)
    );

    assign eval_s = (phase_s == GREEN) || (phase_s == RED);

    // Next results: config latch on start, otherwise per-lane elimination and
    // a single lowest-index finisher per cycle.
    always_comb begin
        finished_d   = finished_q;
        eliminated_d = eliminated_q;
        place_d      = place_q;
        next_place_d = next_place_q;
        win_d        = 1'b0;
        max_clicks_d = max_clicks_q;
        max_steps_d  = max_steps_q;
        picked_s     = 1'b0;
        if (load_s) begin
            max_clicks_d = cfg_clicks;
            max_steps_d  = (cfg_steps == 4'd0) ? 4'd1 : cfg_steps;
            finished_d   = '0;
            eliminated_d = '0;
            place_d      = '0;
            next_place_d = 3'd1;
        end else if (eval_s) begin
            // Ascending loop with a picked flag gives lowest-index priority.
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (!finished_q[i] && !eliminated_q[i]) begin
                    if (!bus.status_bus[POS_W*i + STATUS_OK_BIT]) begin
                        eliminated_d[i] = 1'b1;
                    end else if ((bus.position_bus[POS_W*i +: POS_W] >= max_steps_q) && !picked_s) begin
                        picked_s                      = 1'b1;
                        finished_d[i]                 = 1'b1;
                        place_d[PLACE_W*i +: PLACE_W] = next_place_q;
                        win_d                         = 1'b1;
                        next_place_d                  = place_inc(next_place_q);
                    end else begin
                        picked_s = picked_s;
                    end
                end else begin
                    picked_s = picked_s;
                end
            end
        end else begin
            win_d = 1'b0;
        end
    end

    assign force_done_s = eval_s && (&(finished_d | eliminated_d));

    // Result and target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            finished_q   <= '0;
            eliminated_q <= '0;
            place_q      <= '0;
            next_place_q <= 3'd1;
            win_q        <= 1'b0;
            max_clicks_q <= 4'd0;
            max_steps_q  <= 4'd0;
        end else begin
            finished_q   <= finished_d;
            eliminated_q <= eliminated_d;
            place_q      <= place_d;
            next_place_q <= next_place_d;
            win_q        <= win_d;
            max_clicks_q <= max_clicks_d;
            max_steps_q  <= max_steps_d;
        end
    end

    assign bus.win        = win_q;
    assign bus.max_clicks = max_clicks_q;
    assign bus.max_steps  = max_steps_q;
    assign finished       = finished_q;
    assign eliminated     = eliminated_q;
    assign place_bus      = place_q;
    assign phase          = phase_s;
endmodule

// File: tb/tb_race_referee.sv
// tb_race_referee: directed + randomized bench for race_referee with a
// game-level reference model (phase from elapsed cycles, ranking from arrays).
module tb_race_referee;
    localparam int NP = 4;
    localparam int CD = 3;
    localparam int GC = 8;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    cfg_clicks = 4'd0;
    logic [3:0]    cfg_steps = 4'd0;
    logic [NP-1:0] finished;
    logic [NP-1:0] eliminated;
    logic [3*NP-1:0] place_bus;
    logic          game_over;
    logic [2:0]    phase;

    int pos [NP];
    bit ok  [NP];

    int tests = 0;
    int fails = 0;

    // model state
    int m_phase, m_t, m_next, m_mc, m_ms;
    bit m_win;
    bit m_fin [NP];
    bit m_elim [NP];
    int m_place [NP];

    race_referee_if #(.NUM_PLAYERS(NP)) gif();

    race_referee #(
        .NUM_PLAYERS(NP), .COUNTDOWN_CYCLES(CD), .GREEN_CYCLES(GC),
        .RED_CYCLES(RC), .TIMER_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_clicks (cfg_clicks),
        .cfg_steps  (cfg_steps),
        .bus        (gif.master),
        .finished   (finished),
        .eliminated (eliminated),
        .place_bus  (place_bus),
        .game_over  (game_over),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            gif.position_bus[4*i +: 4] = pos[i][3:0];
            gif.status_bus[4*i +: 4]   = ok[i] ? 4'b1000 : 4'b0001;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int phase_of(input int t);
        if (t < CD) return 1;
        if (((t - CD) % (GC + RC)) < GC) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_next = 1; m_mc = 0; m_ms = 0; m_win = 0;
        for (int i = 0; i < NP; i++) begin
            m_fin[i] = 0; m_elim[i] = 0; m_place[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit picked;
        bit all_done;
        m_win = 0;
        if ((m_phase == 0 || m_phase == 4) && start) begin
            m_mc = int'(cfg_clicks);
            m_ms = (cfg_steps == 4'd0) ? 1 : int'(cfg_steps);
            for (int i = 0; i < NP; i++) begin
                m_fin[i] = 0; m_elim[i] = 0; m_place[i] = 0;
            end
            m_next = 1; m_t = 0; m_phase = 1;
        end else if (m_phase == 2 || m_phase == 3) begin
            picked = 0;
            for (int i = 0; i < NP; i++) begin
                if (!m_fin[i] && !m_elim[i]) begin
                    if (!ok[i]) m_elim[i] = 1;
                    else if (pos[i] >= m_ms && !picked) begin
                        picked = 1; m_fin[i] = 1; m_place[i] = m_next; m_win = 1;
                        if (m_next < 7) m_next++;
                    end
                end
            end
            all_done = 1;
            for (int i = 0; i < NP; i++) if (!m_fin[i] && !m_elim[i]) all_done = 0;
            if (all_done) m_phase = 4;
            else begin m_t++; m_phase = phase_of(m_t); end
        end else if (m_phase == 1) begin
            m_t++; m_phase = phase_of(m_t);
        end
    endtask

    task automatic check_all();
        logic [NP-1:0]   e_fin, e_elim;
        logic [3*NP-1:0] e_place;
        for (int i = 0; i < NP; i++) begin
            e_fin[i]  = m_fin[i];
            e_elim[i] = m_elim[i];
            e_place[3*i +: 3] = 3'(m_place[i]);
        end
        chk("phase",      32'(phase),          32'(m_phase));
        chk("enable",     32'(gif.enable),     32'(m_phase == 2 || m_phase == 3));
        chk("red",        32'(gif.red),        32'(m_phase != 2));
        chk("win",        32'(gif.win),        32'(m_win));
        chk("game_over",  32'(game_over),      32'(m_phase == 4));
        chk("max_clicks", 32'(gif.max_clicks), 32'(m_mc));
        chk("max_steps",  32'(gif.max_steps),  32'(m_ms));
        chk("finished",   32'(finished),       32'(e_fin));
        chk("eliminated", 32'(eliminated),     32'(e_elim));
        chk("place_bus",  32'(place_bus),      32'(e_place));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until(input int p, input int budget);
        for (int k = 0; k < budget && m_phase != p; k++) step();
        chk("wait_phase", 32'(m_phase), 32'(p));
    endtask

    task automatic begin_game(input logic [3:0] clicks, input logic [3:0] stp);
        for (int i = 0; i < NP; i++) begin pos[i] = 0; ok[i] = 1; end
        cfg_clicks = clicks; cfg_steps = stp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin pos[i] = 0; ok[i] = 1; end
        model_reset();
        #12;
        check_all();
        @(negedge clk); rst = 1'b0;
        steps(2);

        // Light timing plus single finisher in GREEN.
        begin_game(4'd3, 4'd5);
        steps(30);
        run_until(2, 20);
        pos[2] = 5;
        steps(3);
        // Two players reach the target together: consecutive win pulses.
        pos[0] = 5; pos[3] = 5;
        steps(3);
        chk("place_p0", 32'(place_bus[2:0]), 32'd2);
        chk("place_p3", 32'(place_bus[11:9]), 32'd3);
        pos[1] = 9;
        run_until(4, 20);
        steps(2);

        // Config edge (steps 0 -> 1), two finishers, two eliminations on RED.
        begin_game(4'd15, 4'd0);
        run_until(2, 20);
        pos[0] = 1; pos[1] = 1;
        steps(3);
        run_until(3, 30);
        ok[2] = 0; ok[3] = 0;
        steps(2);
        chk("elim_final", 32'(eliminated), 32'h0000000c);
        chk("over_final", 32'(game_over), 32'd1);
        steps(2);

        // Randomized play.
        for (int k = 0; k < 600; k++) begin
            start = ($urandom_range(0, 19) == 0);
            cfg_clicks = 4'($urandom);
            cfg_steps  = 4'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 5) == 0) pos[i] = $urandom_range(0, 15);
                ok[i] = ($urandom_range(0, 40) != 0);
            end
            step();
        end
        start = 1'b0;

        // Asynchronous reset in the middle of GREEN with a finisher pending.
        begin_game(4'd2, 4'd9);
        run_until(2, 20);
        pos[1] = 15;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        steps(2);
        @(negedge clk); rst = 1'b0;
        steps(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
